pe_bram_arbiter: RTL
====================

# pe_bram_arbiter

Round-robin arbiter that shares the single PS-side BRAM port among NUM_REQ PE controllers. Each controller requests the port, owns it for an entire burst (a load phase or a result write-back), then releases it. The arbiter drives the BRAM_* bus from the current owner and routes read-data-valid back to that owner. It sits between the PE controller array and the AXI BRAM controller port, in the aclk domain.

## Interface
Parameters:
- NUM_REQ, 4: number of requesting PE controllers (2..8).
- ADDR_W, 32: BRAM byte-address width.
- HOLD_LIMIT, 64: maximum consecutive owned cycles when preemption is compiled in.

Ports:
- aclk  in  1  single clock; BRAM_CLK is driven from it.
- areset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester port request; held high for the whole burst.
- req_addr  in  NUM_REQ*ADDR_W  packed per-requester byte address.
- req_wrdata  in  NUM_REQ*32  packed per-requester write data.
- req_we  in  NUM_REQ*4  packed per-requester byte write enables.
- grant  out  NUM_REQ  one-hot registered grant.
- rd_valid  out  NUM_REQ  one-hot; BRAM_RDDATA is valid for that requester this cycle.
- rd_data  out  32  BRAM_RDDATA broadcast to all requesters.
- BRAM_ADDR  out  ADDR_W  muxed address.
- BRAM_WRDATA  out  32  muxed write data.
- BRAM_WE  out  4  muxed byte enables.
- BRAM_CLK  out  1  equals aclk.
- BRAM_RDDATA  in  32  BRAM read data, 1-cycle latency.

## Operation
- States: IDLE (no owner) and BUSY (owner = owner_idx).
- Arbitration runs in IDLE, and in BUSY on any cycle where req[owner_idx] is low. The winner is the first set req bit, scanning upward from (last_owner+1) mod NUM_REQ.
- The winner's grant bit and owner_idx are registered. The state is BUSY from the next edge, and last_owner is updated to the winner.
- Lock: while req[owner_idx] stays high, grant does not move, regardless of other requests.
- Release: when req[owner_idx] drops in cycle t, the bus is gated idle in cycle t. Grant moves to the next winner at edge t+1, or to zero and IDLE if no requests are pending.
- Bus mux: an access is active when grant[i] && req[i]. Active cycle: BRAM_ADDR/WRDATA/WE come from requester i. Otherwise BRAM_ADDR=0, BRAM_WRDATA=0, BRAM_WE=0.
- Read tracking: an active cycle with req_we[i]==0 sets rd_valid[i] on the following cycle. This bit is registered and remains correct even if the grant moved in between.
- A requester must not drive accesses without grant. The arbiter ignores its signals and flags nothing.
- Reset values:
  - grant=0, rd_valid=0, BRAM_ADDR=0, BRAM_WRDATA=0, BRAM_WE=0.
  - State IDLE, last_owner=NUM_REQ-1, so requester 0 wins first after reset.
  - Hold counter 0.
- Reset during BUSY: all grants drop at the reset edge. An in-flight rd_valid is discarded.

## Timing
- Request-to-grant: req rises at t with the arbiter idle; grant at t+1; first access at t+1.
- Handoff: owner drops req at t; next owner granted at t+1. Exactly one idle bus cycle.
- Read data: access at t; rd_valid and rd_data at t+1.
- Simultaneous release and new request: the new request participates in arbitration in the release cycle.
- Single requester: re-asserting req one cycle after a release re-grants it. No starvation penalty.

## Configuration
- PE_ARB_HOLD_LIMIT_EN defined:
  - A hold counter counts owned BUSY cycles and resets on each new grant.
  - When it reaches HOLD_LIMIT and another req bit is set, the owner is preempted: grant drops at the next edge, followed by normal arbitration, so the next owner is granted one cycle later.
  - The preempted requester keeps req high and is re-granted in round-robin order. Its controller stalls while grant is low.
  - With no other request pending, the owner keeps the port and the counter saturates.
- Not defined: there is no counter, and the lock is unlimited.

## Structure
- Shared package pe_pkg holds:
  - localparams BRAM_DATA_W=32 and BRAM_WE_W=4;
  - the state encoding ARB_IDLE/ARB_BUSY;
  - the default result-base address used by PE controllers.
- One sub-module, rr_pick: combinational round-robin priority encoder. Inputs are the req vector and the start index; outputs are a winner one-hot and a found flag.

## Test plan
- Reset, then req=4'b0001: grant=0001 one cycle later. Access addr 0x200, we=0: rd_valid=0001 the next cycle, rd_data equals the BRAM word.
- req=4'b1111 simultaneously, each holding 3 cycles then releasing: grant order 0,1,2,3. Exactly one idle bus cycle (WE=0, ADDR=0) between bursts.
- Owner 2 writes we=4'hF, data 0xDEADBEEF to 0x204 while req 0 is pending: grant does not move until req[2] drops. A readback by requester 0 returns 0xDEADBEEF.
- Read issued at the last owned cycle of requester 1, with requester 3 granted next cycle: rd_valid=0010, never 1000.
- areset pulse mid-burst of requester 1: grant=0 and rd_valid=0 after the reset edge. With req=4'b0011 the next winner is requester 0.
- With PE_ARB_HOLD_LIMIT_EN, HOLD_LIMIT=8, req 0 and 1 held continuously: grant alternates 0 for 8 cycles, 0 (none) for 1, 1 for 8, repeating. Without the macro, requester 0 holds indefinitely.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the PE controller array and its BRAM port arbiter.
// Contents: BRAM data/byte-enable widths, arbiter state encoding, and the
// default result-base byte address used by the PE controllers.
package pe_pkg;

  localparam int unsigned BRAM_DATA_W = 32;
  localparam int unsigned BRAM_WE_W   = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Where PE controllers write results unless software relocates them.
  localparam logic [31:0] RESULT_BASE_ADDR = 32'h0000_1000;

endpackage

// File: rtl/pe_bram_arbiter_if.sv
// Bus between the PE controller array / BRAM and the BRAM port arbiter.
// master: requester side plus BRAM read data (drives req*, BRAM_RDDATA).
// slave : arbiter side (drives grant, rd_valid, rd_data, BRAM_* outputs).
//   req        per-requester request, held for the whole burst
//   req_addr   packed per-requester byte addresses
//   req_wrdata packed per-requester write data
//   req_we     packed per-requester byte enables
//   grant      one-hot registered grant
//   rd_valid   one-hot read-data-valid, rd_data is BRAM_RDDATA broadcast
//   BRAM_*     shared BRAM port (BRAM_RDDATA has 1-cycle latency)
interface pe_bram_arbiter_if
  import pe_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*ADDR_W-1:0]      req_addr;
  logic [NUM_REQ*BRAM_DATA_W-1:0] req_wrdata;
  logic [NUM_REQ*BRAM_WE_W-1:0]   req_we;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             rd_valid;
  logic [BRAM_DATA_W-1:0]         rd_data;
  logic [ADDR_W-1:0]              BRAM_ADDR;
  logic [BRAM_DATA_W-1:0]         BRAM_WRDATA;
  logic [BRAM_WE_W-1:0]           BRAM_WE;
  logic                           BRAM_CLK;
  logic [BRAM_DATA_W-1:0]         BRAM_RDDATA;

  modport master (
    output req, req_addr, req_wrdata, req_we, BRAM_RDDATA,
    input  grant, rd_valid, rd_data, BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_CLK
  );

  modport slave (
    input  req, req_addr, req_wrdata, req_we, BRAM_RDDATA,
    output grant, rd_valid, rd_data, BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_CLK
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
//   i_req    request vector
//   i_start  index where the upward, wrapping scan begins
//   o_winner one-hot first set request at or after i_start
//   o_found  any request set
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_start,
  output logic [NUM_REQ-1:0] o_winner,
  output logic               o_found
);
  logic [31:0]   w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    w_sum    = '0;
    w_idx    = '0;
    o_winner = '0;
    o_found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = 32'(i_start) + 32'(k);
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_idx = w_sum[IW-1:0];
      if (!o_found && i_req[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        o_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_bram_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ PE controllers.
// An owner keeps the port for as long as it holds req; the bus is gated idle
// in the cycle req drops and the next winner is granted at the following edge.
//   aclk   clock (also forwarded as BRAM_CLK)
//   areset synchronous active-high reset
//   bus    pe_bram_arbiter_if.slave: requester bus and BRAM port
// Optional feature macro PE_ARB_HOLD_LIMIT_EN: preempt an owner after
// HOLD_LIMIT owned cycles when another requester is waiting.
module pe_bram_arbiter
  import pe_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned HOLD_LIMIT = 64
) (
  input logic              aclk,
  input logic              areset,
  pe_bram_arbiter_if.slave bus
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e             r_state, w_state_d;
  logic [NUM_REQ-1:0]     r_grant, w_grant_d;
  logic [NUM_REQ-1:0]     r_rd_valid, w_rd_valid_d;
  logic [NUM_REQ-1:0]     w_active, w_winner;
  logic [IW-1:0]          r_owner, w_owner_d;
  logic [IW-1:0]          r_last_owner, w_last_owner_d;
  logic [IW-1:0]          w_start, w_win_idx;
  logic                   w_found, w_arb, w_preempt;
  logic [ADDR_W-1:0]      w_addr;
  logic [BRAM_DATA_W-1:0] w_wrdata;
  logic [BRAM_WE_W-1:0]   w_we;

  assign w_start = (r_last_owner == IW'(NUM_REQ - 1)) ? '0 : r_last_owner + 1'b1;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req    (bus.req),
    .i_start  (w_start),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner[i]) w_win_idx = IW'(i);
    end
  end

`ifdef PE_ARB_HOLD_LIMIT_EN
  localparam int unsigned CW = $clog2(HOLD_LIMIT + 1);
  logic [CW-1:0] r_hold_cnt, w_hold_cnt_d;

  // Counts owned cycles including the current one, so the owner gets exactly
  // HOLD_LIMIT cycles before it can be preempted.
  assign w_preempt = (r_state == ARB_BUSY) && bus.req[r_owner] &&
                     (r_hold_cnt >= CW'(HOLD_LIMIT)) && |(bus.req & ~r_grant);

  always_comb begin
    w_hold_cnt_d = r_hold_cnt;
    if (w_preempt) begin
      w_hold_cnt_d = '0;
    end else if (w_arb) begin
      w_hold_cnt_d = w_found ? CW'(1) : '0;
    end else if (r_hold_cnt < CW'(HOLD_LIMIT)) begin
      w_hold_cnt_d = r_hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) r_hold_cnt <= '0;
    else        r_hold_cnt <= w_hold_cnt_d;
  end
`else
  logic w_unused_hold_limit;
  assign w_unused_hold_limit = ^HOLD_LIMIT;
  assign w_preempt           = 1'b0;
`endif

  // Arbitrate when idle or when the owner has released its request.
  always_comb begin
    w_state_d      = r_state;
    w_grant_d      = r_grant;
    w_owner_d      = r_owner;
    w_last_owner_d = r_last_owner;
    w_arb          = (r_state == ARB_IDLE) || !bus.req[r_owner];
    if (w_preempt) begin
      // Drop the grant for one cycle; normal arbitration runs from IDLE.
      w_state_d = ARB_IDLE;
      w_grant_d = '0;
    end else if (w_arb) begin
      if (w_found) begin
        w_state_d      = ARB_BUSY;
        w_grant_d      = w_winner;
        w_owner_d      = w_win_idx;
        w_last_owner_d = w_win_idx;
      end else begin
        w_state_d = ARB_IDLE;
        w_grant_d = '0;
      end
    end
  end

  // Bus mux; grant is one-hot so at most one requester is active.
  always_comb begin
    w_addr       = '0;
    w_wrdata     = '0;
    w_we         = '0;
    w_rd_valid_d = '0;
    w_active     = r_grant & bus.req;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_active[i]) begin
        w_addr          = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_wrdata        = bus.req_wrdata[i*BRAM_DATA_W +: BRAM_DATA_W];
        w_we            = bus.req_we[i*BRAM_WE_W +: BRAM_WE_W];
        w_rd_valid_d[i] = (bus.req_we[i*BRAM_WE_W +: BRAM_WE_W] == '0);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_last_owner <= IW'(NUM_REQ - 1);
      r_rd_valid   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_grant      <= w_grant_d;
      r_owner      <= w_owner_d;
      r_last_owner <= w_last_owner_d;
      r_rd_valid   <= w_rd_valid_d;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_data     = bus.BRAM_RDDATA;
  assign bus.BRAM_ADDR   = w_addr;
  assign bus.BRAM_WRDATA = w_wrdata;
  assign bus.BRAM_WE     = w_we;
  assign bus.BRAM_CLK    = aclk;

endmodule
